// File: rtl/priority_arbiter.sv
// priority_arbiter: eight-requester arbiter with fixed or round-robin
// priority, bounded grant hold and fully registered outputs.
module priority_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       rr_mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld
);

    localparam int unsigned   HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [2:0]    ptr;
    logic [2:0]    ptr_d;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] cnt_d;
    logic [7:0]    gnt_d;
    logic [2:0]    id_d;
    logic          vld_d;

    logic [7:0] fix_hot;
    logic [2:0] fix_id;
    logic [2:0] sh;
    logic [7:0] rot;
    logic [7:0] rot_hot;
    logic [2:0] rot_k;
    logic [2:0] rot_id;
    logic [2:0] win_id;
    logic [7:0] win_hot;
    logic       any_req;
    logic       rel;
    logic       take;

    // Keep only the most significant set bit (isolate lowest of reversal).
    function automatic logic [7:0] top_hot(input logic [7:0] v);
        logic [7:0] rev;
        logic [7:0] iso;
        logic [7:0] hot;
        for (int i = 0; i < 8; i++) begin
            rev[i] = v[7-i];
        end
        iso = rev & (~rev + 8'd1);
        for (int i = 0; i < 8; i++) begin
            hot[i] = iso[7-i];
        end
        return hot;
    endfunction

    // One-hot to binary; zero input maps to index 0.
    function automatic logic [2:0] enc8(input logic [7:0] hot);
        logic [2:0] id;
        unique case (1'b1)
            hot[7]:  id = 3'd7;
            hot[6]:  id = 3'd6;
            hot[5]:  id = 3'd5;
            hot[4]:  id = 3'd4;
            hot[3]:  id = 3'd3;
            hot[2]:  id = 3'd2;
            hot[1]:  id = 3'd1;
            hot[0]:  id = 3'd0;
            default: id = 3'd0;
        endcase
        return id;
    endfunction

    // Winner selection: fixed picks the top bit; round-robin rotates req so
    // that index ptr lands on bit 7, then reuses the same top-bit search.
    always_comb begin
        any_req = |req;
        fix_hot = top_hot(req);
        fix_id  = enc8(fix_hot);
        sh      = ptr + 3'd1;
        rot     = 8'({req, req} >> sh);
        rot_hot = top_hot(rot);
        rot_k   = enc8(rot_hot);
        rot_id  = rot_k + sh;
        win_id  = rr_mode ? rot_id : fix_id;
        win_hot = 8'd1 << win_id;
    end

    // Release when the holder drops its request or the burst is used up.
    always_comb begin
        rel = ~req[gnt_id] | (hold_cnt == HOLD_MAX);
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = hold_cnt;
        gnt_d   = gnt;
        id_d    = gnt_id;
        vld_d   = gnt_vld;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && any_req) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!rel) begin
                    cnt_d = hold_cnt + HOLD_ONE;
                end else if (en && any_req) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 8'd0;
                    vld_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'd0;
                vld_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
        if (take) begin
            state_d = GRANT;
            gnt_d   = win_hot;
            id_d    = win_id;
            vld_d   = 1'b1;
            cnt_d   = HOLD_ONE;
            ptr_d   = win_id - 3'd1;
        end
    end

    // State and output registers; reset wins over any held grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd7;
            hold_cnt <= '0;
            gnt      <= 8'd0;
            gnt_id   <= 3'd0;
            gnt_vld  <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            hold_cnt <= cnt_d;
            gnt      <= gnt_d;
            gnt_id   <= id_d;
            gnt_vld  <= vld_d;
        end
    end

endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: scoreboard bench for two arbiter instances
// (MAX_HOLD 4 and 1) sharing one randomized input stream.
module tb_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = 8'd0;
    logic       rr_mode = 1'b0;

    logic [7:0] gnt_a;
    logic [2:0] id_a;
    logic       vld_a;
    logic [7:0] gnt_b;
    logic [2:0] id_b;
    logic       vld_b;

    always #5 clk = ~clk;

    priority_arbiter #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req), .rr_mode(rr_mode),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_vld(vld_a)
    );

    priority_arbiter #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req), .rr_mode(rr_mode),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b)
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state per instance: holder (-1 = none), last id, burst
    // length so far, and the index searched first in round-robin mode.
    int m_gid[2];
    int m_last[2];
    int m_cnt[2];
    int m_ptr[2];
    int maxh[2];

    function automatic int pick(input logic [7:0] r, input logic rr,
                                input int p);
        if (!rr) begin
            for (int i = 7; i >= 0; i--)
                if (r[i]) return i;
        end else begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (p - k + 8) % 8;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic step_model(input int d, output exp_t e);
        int  w;
        bit  busy;
        bit  rel;
        if (rst) begin
            m_gid[d]  = -1;
            m_last[d] = 0;
            m_cnt[d]  = 0;
            m_ptr[d]  = 7;
        end else begin
            busy = (m_gid[d] >= 0);
            rel  = busy && (!req[m_gid[d]] || m_cnt[d] == maxh[d]);
            if (busy && !rel) begin
                m_cnt[d] = m_cnt[d] + 1;
            end else if (en && req != 8'd0) begin
                w         = pick(req, rr_mode, m_ptr[d]);
                m_gid[d]  = w;
                m_last[d] = w;
                m_cnt[d]  = 1;
                m_ptr[d]  = (w + 7) % 8;
            end else begin
                m_gid[d] = -1;
                m_cnt[d] = 0;
            end
        end
        e.gnt = 8'd0;
        if (m_gid[d] >= 0) e.gnt[m_gid[d]] = 1'b1;
        e.id  = 3'(m_last[d]);
        e.vld = (m_gid[d] >= 0);
    endtask

    task automatic drive(input logic r, input logic e_in,
                         input logic [7:0] q, input logic m);
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        rst     = r;
        en      = e_in;
        req     = q;
        rr_mode = m;
        step_model(0, ea);
        qa.push_back(ea);
        step_model(1, eb);
        qb.push_back(eb);
    endtask

    task automatic check(input string nm, input logic [7:0] g,
                         input logic [2:0] i, input logic v,
                         input exp_t e);
        n_cmp++;
        if (g !== e.gnt || i !== e.id || v !== e.vld) begin
            n_bad++;
            $display("FAIL %s @%0t: got gnt=%b id=%0d vld=%b, want gnt=%b id=%0d vld=%b",
                     nm, $time, g, i, v, e.gnt, e.id, e.vld);
        end
    endtask

    // Monitor: after each rising edge, pop one expectation per instance.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("arb_hold4", gnt_a, id_a, vld_a, e);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("arb_hold1", gnt_b, id_b, vld_b, e);
            end
        end
    end

    initial begin
        logic [7:0] rq;
        logic       rm;
        logic       re;
        int         left;
        maxh[0] = 4;
        maxh[1] = 1;
        for (int d = 0; d < 2; d++) begin
            m_gid[d]  = -1;
            m_last[d] = 0;
            m_cnt[d]  = 0;
            m_ptr[d]  = 7;
        end

        // Reset overrides full requests; first grant goes to 7.
        repeat (2) drive(1'b1, 1'b1, 8'hFF, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 8'hFF, 1'b0);
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        repeat (3) drive(1'b0, 1'b1, 8'hFF, 1'b1);

        // Fixed priority with a held 0010_0110 request.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (10) drive(1'b0, 1'b1, 8'b0010_0110, 1'b0);

        // Round-robin over the same request: 5, 2, 1, 5 ...
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (20) drive(1'b0, 1'b1, 8'b0010_0110, 1'b1);

        // Early release of 3 handing over to 0, then release to idle.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 8'b0000_1001, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 8'b0000_0001, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 8'b0000_1000, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 8'b0000_0000, 1'b0);

        // Enable gating: no grant while low, finish hold after dropping.
        repeat (10) drive(1'b0, 1'b0, 8'h81, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 8'h81, 1'b0);
        repeat (6) drive(1'b0, 1'b0, 8'h81, 1'b0);

        // Mid-burst reset with requester 4 still asking.
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) drive(1'b0, 1'b1, 8'h10, 1'b1);
        drive(1'b1, 1'b1, 8'h10, 1'b1);
        repeat (3) drive(1'b0, 1'b1, 8'h10, 1'b1);

        // Randomized traffic with persistent requests and mode flips.
        rq = 8'h00;
        rm = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 7))
                0:       rq = 8'h00;
                1:       rq = 8'd1 << $urandom_range(0, 7);
                2, 3:    rq = 8'($urandom());
                default: rq = rq;
            endcase
            if ($urandom_range(0, 15) == 0) rq = 8'hFF;
            if ($urandom_range(0, 31) == 0) rm = ~rm;
            re = ($urandom_range(0, 7) != 0);
            drive(($urandom_range(0, 99) == 0), re, rq, rm);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        left = 0;
        while ((qa.size() > 0 || qb.size() > 0) && left < 10) begin
            @(posedge clk);
            left++;
        end
        #2;
        n_cmp++;
        if (qa.size() > 0 || qb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0",
                     qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
